tlul_reg_host_arb: RTL and testbench

Round-robin arbiter that shares one TL-UL host port among `NumReq` simple register requesters. It sits in front of a TL-UL device such as a register-interface adapter. Each requester issues word-wide register reads and writes over a req/gnt handshake. The block serialises those requests into single-beat TL-UL transactions, with at most one outstanding, and routes each response back to the requester that owns it.

---
 rtl/tlul_pkg.sv | 62 ++++++
 rtl/tlul_reg_host_arb.sv | 195 +++++++++++++++++++
 tb/tb_tlul_reg_host_arb.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlul_pkg.sv
// Minimal TL-UL type package: the request/response channel structs and opcodes
// used by register-interface hosts and devices in this codebase.
package tlul_pkg;

  localparam int TL_AW  = 32;  // address width
  localparam int TL_DW  = 32;  // data width
  localparam int TL_AIW = 8;   // source id width
  localparam int TL_DIW = 1;   // sink id width
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_SZW = 2;   // size field width

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [4:0] rsvd;
    logic [3:0] instr_type;
  } tl_a_user_t;

  // Data accesses are marked as "not an instruction fetch".
  localparam tl_a_user_t TL_A_USER_DEFAULT = '{rsvd: 5'h0, instr_type: 4'b1001};

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic                a_valid;
    tl_a_op_e            a_opcode;
    logic [2:0]          a_param;
    logic [TL_SZW-1:0]   a_size;
    logic [TL_AIW-1:0]   a_source;
    logic [TL_AW-1:0]    a_address;
    logic [TL_DBW-1:0]   a_mask;
    logic [TL_DW-1:0]    a_data;
    tl_a_user_t          a_user;
    logic                d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                d_valid;
    tl_d_op_e            d_opcode;
    logic [2:0]          d_param;
    logic [TL_SZW-1:0]   d_size;
    logic [TL_AIW-1:0]   d_source;
    logic [TL_DIW-1:0]   d_sink;
    logic [TL_DW-1:0]    d_data;
    tl_d_user_t          d_user;
    logic                d_error;
    logic                a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_reg_host_arb.sv
// tlul_reg_host_arb: round-robin arbiter sharing one TL-UL host port among
// NumReq word-wide register requesters. One transaction outstanding at a time;
// each response is routed back to the requester that issued the request.
// Optional feature: define TLUL_REG_HOST_ARB_TIMEOUT_EN to complete a request
// with an error when the device does not respond within TimeoutCycles cycles
// of entering the data phase.
module tlul_reg_host_arb
  import tlul_pkg::*;
#(
  parameter int NumReq        = 4,
  parameter int RegAw         = 12,
  parameter int TimeoutCycles = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumReq-1:0]            req_i,
  output logic [NumReq-1:0]            gnt_o,
  input  logic [NumReq-1:0]            we_i,
  input  logic [NumReq-1:0][RegAw-1:0] addr_i,
  input  logic [NumReq-1:0][31:0]      wdata_i,
  input  logic [NumReq-1:0][3:0]       be_i,
  output logic [NumReq-1:0]            rsp_valid_o,
  output logic [31:0]                  rsp_rdata_o,
  output logic                         rsp_err_o,
  output tl_h2d_t                      tl_o,
  input  tl_d2h_t                      tl_i,
  output logic                         busy_o
);

  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam logic [IdxW-1:0] LastInit = IdxW'(NumReq - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2
  } state_e;

  state_e                  state_reg;
  logic [IdxW-1:0]         idx_reg;
  logic [IdxW-1:0]         last_reg;
  logic                    we_reg;
  logic [RegAw-3:0]        addr_reg;   // word address; byte offset is always 0
  logic [31:0]             wdata_reg;
  logic [3:0]              be_reg;
  logic [NumReq-1:0]       rsp_valid_reg;
  logic [31:0]             rsp_rdata_reg;
  logic                    rsp_err_reg;

  logic                    win_found;
  logic [IdxW-1:0]         win_idx;
  int                      cand;
  logic                    src_mismatch;
  logic                    rsp_err_next;

`ifdef TLUL_REG_HOST_ARB_TIMEOUT_EN
  localparam int TmoW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);
  logic [TmoW-1:0]         tmo_cnt_reg;
`else
  logic                    unused_tmo_param;
  assign unused_tmo_param = ^TimeoutCycles;
`endif

  // Round-robin pick: first requester set scanning upward from last+1,
  // wrapping at NumReq. Scanning from the farthest offset down lets the
  // nearest candidate overwrite, so no early exit is needed.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = NumReq; k >= 1; k--) begin
      cand = int'(last_reg) + k;
      if (cand >= NumReq) begin
        cand = cand - NumReq;
      end
      if (req_i[cand[IdxW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IdxW-1:0];
      end
    end
  end

  // Grant pulse is combinational and only issued while idle.
  for (genvar gi = 0; gi < NumReq; gi++) begin : g_gnt
    assign gnt_o[gi] = (state_reg == StIdle) && win_found && (win_idx == IdxW'(gi));
  end

  // The byte-offset bits of each requester address never reach the bus.
  logic [NumReq-1:0][1:0] unused_addr_lsb;
  for (genvar gi = 0; gi < NumReq; gi++) begin : g_addr_lsb
    assign unused_addr_lsb[gi] = addr_i[gi][1:0];
  end

  // A response with a source id other than the one we issued is treated as
  // an error but is still delivered to the current owner.
  assign src_mismatch = (tl_i.d_source != {{(TL_AIW-IdxW){1'b0}}, idx_reg});
  assign rsp_err_next = tl_i.d_error | src_mismatch;

  // Transaction FSM: capture on grant, drive A channel, wait for D channel.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= StIdle;
      idx_reg       <= '0;
      last_reg      <= LastInit;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      be_reg        <= '0;
      rsp_valid_reg <= '0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
`ifdef TLUL_REG_HOST_ARB_TIMEOUT_EN
      tmo_cnt_reg   <= '0;
`endif
    end else begin
      rsp_valid_reg <= '0;
      unique case (state_reg)
        StIdle: begin
          if (win_found) begin
            idx_reg   <= win_idx;
            last_reg  <= win_idx;
            we_reg    <= we_i[win_idx];
            addr_reg  <= addr_i[win_idx][RegAw-1:2];
            wdata_reg <= wdata_i[win_idx];
            be_reg    <= be_i[win_idx];
            state_reg <= StAddr;
          end
        end
        StAddr: begin
          if (tl_i.a_ready) begin
            state_reg   <= StData;
`ifdef TLUL_REG_HOST_ARB_TIMEOUT_EN
            tmo_cnt_reg <= '0;
`endif
          end
        end
        StData: begin
          if (tl_i.d_valid) begin
            rsp_valid_reg[idx_reg] <= 1'b1;
            rsp_err_reg            <= rsp_err_next;
            rsp_rdata_reg          <= rsp_err_next ? 32'hFFFF_FFFF : tl_i.d_data;
            state_reg              <= StIdle;
          end
`ifdef TLUL_REG_HOST_ARB_TIMEOUT_EN
          else if (tmo_cnt_reg == TmoLast) begin
            // Give up: report an error; the late response becomes a stray.
            rsp_valid_reg[idx_reg] <= 1'b1;
            rsp_err_reg            <= 1'b1;
            rsp_rdata_reg          <= 32'hFFFF_FFFF;
            state_reg              <= StIdle;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TmoW'(1);
          end
`endif
        end
        default: begin
          state_reg <= StIdle;
        end
      endcase
    end
  end

  // A channel driven purely from captured state; D channel always accepted.
  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = (state_reg == StAddr);
    if (!we_reg) begin
      tl_o.a_opcode = Get;
    end else if (be_reg == 4'hF) begin
      tl_o.a_opcode = PutFullData;
    end else begin
      tl_o.a_opcode = PutPartialData;
    end
    tl_o.a_param   = 3'h0;
    tl_o.a_size    = TL_SZW'(2);
    tl_o.a_source  = {{(TL_AIW-IdxW){1'b0}}, idx_reg};
    tl_o.a_address = {{(TL_AW-RegAw){1'b0}}, addr_reg, 2'b00};
    tl_o.a_mask    = we_reg ? be_reg : 4'hF;
    tl_o.a_data    = wdata_reg;
    tl_o.a_user    = TL_A_USER_DEFAULT;
    tl_o.d_ready   = 1'b1;
  end

  // D-channel fields this host has no use for.
  logic unused_tl;
  assign unused_tl = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size,
                       tl_i.d_sink, tl_i.d_user, unused_addr_lsb};

  assign rsp_valid_o = rsp_valid_reg;
  assign rsp_rdata_o = rsp_rdata_reg;
  assign rsp_err_o   = rsp_err_reg;
  assign busy_o      = (state_reg != StIdle);

endmodule

// File: tb/tb_tlul_reg_host_arb.sv
// Directed testbench for tlul_reg_host_arb with a response scoreboard.
// Inputs are driven just after the falling edge; outputs are sampled 1 time
// unit later, well away from the rising (active) edge.
module tb_tlul_reg_host_arb;
  import tlul_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]        req = '0;
  logic [N-1:0]        gnt;
  logic [N-1:0]        we = '0;
  logic [N-1:0][11:0]  addr = '0;
  logic [N-1:0][31:0]  wdata = '0;
  logic [N-1:0][3:0]   be = '0;
  logic [N-1:0]        rsp_valid;
  logic [31:0]         rdata;
  logic                err;
  logic                busy;
  tl_h2d_t             tl_h;
  tl_d2h_t             tl_d = '0;

  tlul_reg_host_arb #(
    .NumReq(N),
    .RegAw(12),
    .TimeoutCycles(8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_i(req),
    .gnt_o(gnt),
    .we_i(we),
    .addr_i(addr),
    .wdata_i(wdata),
    .be_i(be),
    .rsp_valid_o(rsp_valid),
    .rsp_rdata_o(rdata),
    .rsp_err_o(err),
    .tl_o(tl_h),
    .tl_i(tl_d),
    .busy_o(busy)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int exp_last = N - 1;
  logic [31:0] exp_hold_rdata = '0;
  logic        exp_hold_err = 1'b0;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [N-1:0] m);
    for (int k = 1; k <= N; k++) begin
      if (m[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // Pop the oldest expected response and compare against the current outputs.
  task automatic check_rsp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_mis++;
      $error("FAIL %s_sb observed=response expected=empty scoreboard", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_valid"}, 32'(rsp_valid), 32'(1) << e.idx);
      check({tag, "_rdata"}, rdata, e.rdata);
      check({tag, "_err"}, 32'(err), 32'(e.err));
      exp_hold_rdata = e.rdata;
      exp_hold_err   = e.err;
      $display("txn %s: requester %0d rdata=%08h err=%0b", tag, e.idx, rdata, err);
    end
  endtask

  // One full transaction, starting just after a falling edge while idle.
  task automatic txn(input string tag, input logic [N-1:0] mask, input logic hold,
                     input logic [31:0] ddata, input logic derr, input logic src_bad,
                     input int a_wait, input int d_wait);
    int w;
    exp_t e;
    logic [31:0] exp_addr;
    logic [31:0] exp_op;
    logic [31:0] exp_mask;
    req = mask;
    #1;
    w = rr_pick(exp_last, mask);
    check({tag, "_gnt"}, 32'(gnt), 32'(1) << w);
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    exp_last = w;
    e.idx   = w;
    e.err   = derr | src_bad;
    e.rdata = e.err ? 32'hFFFF_FFFF : ddata;
    sb.push_back(e);
    exp_op   = !we[w] ? 32'h4 : ((be[w] == 4'hF) ? 32'h0 : 32'h1);
    exp_mask = we[w] ? 32'(be[w]) : 32'hF;
    exp_addr = {20'h0, addr[w][11:2], 2'b00};
    @(negedge clk);
    if (!hold) req = '0;
    for (int i = 0; i <= a_wait; i++) begin
      tl_d.a_ready = (i == a_wait);
      #1;
      check({tag, "_a_valid"}, 32'(tl_h.a_valid), 32'd1);
      check({tag, "_gnt_addr"}, 32'(gnt), 32'd0);
      check({tag, "_rsp_addr"}, 32'(rsp_valid), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_opcode"}, 32'(tl_h.a_opcode), exp_op);
      check({tag, "_address"}, tl_h.a_address, exp_addr);
      check({tag, "_mask"}, 32'(tl_h.a_mask), exp_mask);
      check({tag, "_data"}, tl_h.a_data, wdata[w]);
      check({tag, "_source"}, 32'(tl_h.a_source), 32'(w));
      check({tag, "_size"}, 32'(tl_h.a_size), 32'd2);
      check({tag, "_param"}, 32'(tl_h.a_param), 32'd0);
      check({tag, "_d_ready"}, 32'(tl_h.d_ready), 32'd1);
      @(negedge clk);
    end
    tl_d.a_ready = 1'b0;
    for (int i = 0; i <= d_wait; i++) begin
      if (i == d_wait) begin
        tl_d.d_valid  = 1'b1;
        tl_d.d_data   = ddata;
        tl_d.d_error  = derr;
        tl_d.d_source = 8'(w) ^ (src_bad ? 8'h1 : 8'h0);
      end
      #1;
      check({tag, "_a_valid_data"}, 32'(tl_h.a_valid), 32'd0);
      check({tag, "_rsp_data"}, 32'(rsp_valid), 32'd0);
      check({tag, "_gnt_data"}, 32'(gnt), 32'd0);
      @(negedge clk);
    end
    tl_d.d_valid = 1'b0;
    tl_d.d_error = 1'b0;
    #1;
    check_rsp(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_a_valid", 32'(tl_h.a_valid), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_d_ready", 32'(tl_h.d_ready), 32'd1);

    // Single read, minimum latency
    we[0] = 1'b0; addr[0] = 12'h010; be[0] = 4'hF; wdata[0] = 32'h0;
    txn("read0", 4'b0001, 1'b0, 32'hCAFE_0001, 1'b0, 1'b0, 0, 0);

    // Partial write, then full write, with ready and response delays
    we[2] = 1'b1; addr[2] = 12'h2A7; be[2] = 4'h3; wdata[2] = 32'h1234_5678;
    txn("wr_part", 4'b0100, 1'b0, 32'h0, 1'b0, 1'b0, 2, 0);
    be[2] = 4'hF; wdata[2] = 32'h8765_4321; addr[2] = 12'hFFC;
    txn("wr_full", 4'b0100, 1'b0, 32'h0000_0011, 1'b0, 1'b0, 0, 3);

    // Reset in the data phase abandons the transaction
    we[1] = 1'b0; addr[1] = 12'h044; be[1] = 4'hF;
    req = 4'b0010;
    #1;
    w = rr_pick(exp_last, 4'b0010);
    check("rstmid_gnt", 32'(gnt), 32'(1) << w);
    @(negedge clk);
    req = '0;
    tl_d.a_ready = 1'b1;
    #1;
    check("rstmid_a_valid", 32'(tl_h.a_valid), 32'd1);
    @(negedge clk);
    tl_d.a_ready = 1'b0;
    #1;
    check("rstmid_busy_data", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_last = N - 1;
    #1;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_a_valid0", 32'(tl_h.a_valid), 32'd0);
    check("rstmid_rsp", 32'(rsp_valid), 32'd0);
    check("rstmid_rdata", rdata, 32'd0);
    check("rstmid_err", 32'(err), 32'd0);
    $display("txn rstmid: reset in data phase");
    // Late response from the abandoned transaction is a stray
    tl_d.d_valid = 1'b1; tl_d.d_source = 8'd1; tl_d.d_data = 32'h5A5A_5A5A;
    @(negedge clk);
    tl_d.d_valid = 1'b0;
    #1;
    check("rstmid_stray_rsp", 32'(rsp_valid), 32'd0);
    check("rstmid_stray_rdata", rdata, 32'd0);

    // Round-robin with all requesters held: first winner after reset is 0
    for (int i = 0; i < N; i++) begin
      we[i] = 1'b0; addr[i] = 12'h100 + 12'(i * 4); be[i] = 4'hF;
    end
    for (int t = 0; t < 8; t++) begin
      txn("rr", 4'b1111, 1'b1, 32'hA000_0000 + 32'(t), 1'b0, 1'b0, 0, 0);
    end
    req = '0;

    // Error paths
    txn("derr", 4'b0010, 1'b0, 32'h5555_5555, 1'b1, 1'b0, 0, 1);
    txn("srcbad", 4'b1000, 1'b0, 32'h6666_6666, 1'b0, 1'b1, 1, 0);
    txn("ok_after_err", 4'b0001, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0, 0, 0);

    // Stray response while idle
    tl_d.d_valid = 1'b1; tl_d.d_source = 8'd0; tl_d.d_data = 32'hDEAD_BEEF;
    @(negedge clk);
    tl_d.d_valid = 1'b0;
    #1;
    check("stray_rsp", 32'(rsp_valid), 32'd0);
    check("stray_rdata", rdata, exp_hold_rdata);
    check("stray_err", 32'(err), 32'(exp_hold_err));
    check("stray_busy", 32'(busy), 32'd0);
    $display("txn stray: idle d_valid discarded");

`ifdef TLUL_REG_HOST_ARB_TIMEOUT_EN
    // Device never answers: error response 8 cycles after entering DATA
    begin
      exp_t e;
      we[3] = 1'b0; addr[3] = 12'h3F0; be[3] = 4'hF;
      req = 4'b1000;
      #1;
      w = rr_pick(exp_last, 4'b1000);
      check("tmo_gnt", 32'(gnt), 32'(1) << w);
      exp_last = w;
      e.idx = w; e.rdata = 32'hFFFF_FFFF; e.err = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      req = '0;
      tl_d.a_ready = 1'b1;
      @(negedge clk);
      tl_d.a_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
        #1;
        check("tmo_wait_rsp", 32'(rsp_valid), 32'd0);
        check("tmo_wait_busy", 32'(busy), 32'd1);
        @(negedge clk);
      end
      #1;
      check_rsp("tmo");
      check("tmo_busy", 32'(busy), 32'd0);
      tl_d.d_valid = 1'b1; tl_d.d_source = 8'(w); tl_d.d_data = 32'h1111_2222;
      @(negedge clk);
      tl_d.d_valid = 1'b0;
      #1;
      check("tmo_late_rsp", 32'(rsp_valid), 32'd0);
      check("tmo_late_rdata", rdata, 32'hFFFF_FFFF);
      check("tmo_late_err", 32'(err), 32'd1);
    end
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
